// File: rtl/maxpool_2x2_if.sv
// maxpool_2x2_if -- bus between the activation stage, maxpool_2x2 and the next
// layer's loader.
//   start       one-cycle run request (driven by master)
//   in_matrix   SIZE x SIZE signed activations (driven by master)
//   pool_mode   0 = max, 1 = average (only with MAXPOOL_AVG_EN defined)
//   out_matrix  (SIZE/2) x (SIZE/2) signed pooled result (driven by slave)
//   out_valid   one cycle per window written; out_data/out_row/out_col qualify it
//   busy        high while windows are being produced
//   done        one-cycle completion pulse
// Optional feature macro: MAXPOOL_AVG_EN (adds pool_mode).
interface maxpool_2x2_if #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 10
);
  localparam int RW = SIZE / 2;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;

  logic                    start;
  logic signed [WIDTH-1:0] in_matrix [SIZE][SIZE];
`ifdef MAXPOOL_AVG_EN
  logic                    pool_mode;
`endif
  logic signed [WIDTH-1:0] out_matrix [RW][RW];
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic [IW-1:0]           out_row;
  logic [IW-1:0]           out_col;
  logic                    busy;
  logic                    done;

`ifdef MAXPOOL_AVG_EN
  modport master (
    output start, in_matrix, pool_mode,
    input  out_matrix, out_valid, out_data, out_row, out_col, busy, done
  );
  modport slave (
    input  start, in_matrix, pool_mode,
    output out_matrix, out_valid, out_data, out_row, out_col, busy, done
  );
`else
  modport master (
    output start, in_matrix,
    input  out_matrix, out_valid, out_data, out_row, out_col, busy, done
  );
  modport slave (
    input  start, in_matrix,
    output out_matrix, out_valid, out_data, out_row, out_col, busy, done
  );
`endif
endinterface

// File: rtl/maxpool_2x2.sv
// maxpool_2x2 -- 2x2 stride-2 pooling stage following leaky_relu.
// On start (in IDLE) the SIZE x SIZE activation matrix is snapshotted, then one
// window per clock is pooled in row-major order into out_matrix and streamed on
// out_valid/out_data/out_row/out_col. done pulses once after the last window.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (aborts a run, no done pulse)
//   bus  maxpool_2x2_if.slave (start, in_matrix, [pool_mode], out_matrix,
//        out_valid, out_data, out_row, out_col, busy, done)
// Optional feature macro: MAXPOOL_AVG_EN -- adds pool_mode (1 = floor average
// of the four window values); without it the block is max-only.
module maxpool_2x2 #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 10
) (
  input logic           clk,
  input logic           rst,
  maxpool_2x2_if.slave  bus
);
  localparam int RW = SIZE / 2;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;
  localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;

  generate
    if (SIZE < 2 || (SIZE % 2) != 0) begin : g_size_chk
      $error("maxpool_2x2: SIZE must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, POOL = 2'd1, DONE = 2'd2} state_t;

  state_t                  state;
  logic [IW-1:0]           row_q;
  logic [IW-1:0]           col_q;
  logic signed [WIDTH-1:0] snap [SIZE][SIZE];
`ifdef MAXPOOL_AVG_EN
  logic                    mode_q;
`endif

  logic [SW-1:0]           ri0, ri1, ci0, ci1;
  logic signed [WIDTH-1:0] win_val;

  function automatic logic signed [WIDTH-1:0] max4(
    input logic signed [WIDTH-1:0] p0,
    input logic signed [WIDTH-1:0] p1,
    input logic signed [WIDTH-1:0] p2,
    input logic signed [WIDTH-1:0] p3
  );
    logic signed [WIDTH-1:0] m01;
    logic signed [WIDTH-1:0] m23;
    m01 = (p0 > p1) ? p0 : p1;
    m23 = (p2 > p3) ? p2 : p3;
    return (m01 > m23) ? m01 : m23;
  endfunction

`ifdef MAXPOOL_AVG_EN
  // Sum of four WIDTH-bit values needs two guard bits; dropping the two LSBs
  // of the signed sum is an arithmetic shift by 2 (floor), and the quotient
  // always lies inside the input range so no saturation is needed.
  function automatic logic signed [WIDTH-1:0] avg4(
    input logic signed [WIDTH-1:0] p0,
    input logic signed [WIDTH-1:0] p1,
    input logic signed [WIDTH-1:0] p2,
    input logic signed [WIDTH-1:0] p3
  );
    logic signed [WIDTH+1:0] sum;
    sum = $signed({{2{p0[WIDTH-1]}}, p0}) + $signed({{2{p1[WIDTH-1]}}, p1})
        + $signed({{2{p2[WIDTH-1]}}, p2}) + $signed({{2{p3[WIDTH-1]}}, p3});
    return sum[WIDTH+1:2];
  endfunction
`endif

  // Window select: snapshot rows/cols 2r, 2r+1 and 2c, 2c+1
  always_comb begin
    ri0 = SW'({row_q, 1'b0});
    ri1 = ri0 | SW'(1);
    ci0 = SW'({col_q, 1'b0});
    ci1 = ci0 | SW'(1);
`ifdef MAXPOOL_AVG_EN
    if (mode_q)
      win_val = avg4(snap[ri0][ci0], snap[ri0][ci1], snap[ri1][ci0], snap[ri1][ci1]);
    else
      win_val = max4(snap[ri0][ci0], snap[ri0][ci1], snap[ri1][ci0], snap[ri1][ci1]);
`else
    win_val = max4(snap[ri0][ci0], snap[ri0][ci1], snap[ri1][ci0], snap[ri1][ci1]);
`endif
  end

  // Registered outputs: control FSM, snapshot and result matrix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
`ifdef MAXPOOL_AVG_EN
      mode_q        <= 1'b0;
`endif
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          snap[i][j] <= '0;
      for (int i = 0; i < RW; i++)
        for (int j = 0; j < RW; j++)
          bus.out_matrix[i][j] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start coinciding
          // with it is dropped so a new run always begins from a quiet IDLE.
          if (bus.start && !bus.done) begin
            snap     <= bus.in_matrix;
`ifdef MAXPOOL_AVG_EN
            mode_q   <= bus.pool_mode;
`endif
            row_q    <= '0;
            col_q    <= '0;
            bus.busy <= 1'b1;
            state    <= POOL;
          end
        end
        POOL: begin
          bus.out_matrix[row_q][col_q] <= win_val;
          bus.out_valid <= 1'b1;
          bus.out_data  <= win_val;
          bus.out_row   <= row_q;
          bus.out_col   <= col_q;
          if (col_q == IW'(RW - 1)) begin
            col_q <= '0;
            if (row_q == IW'(RW - 1)) begin
              bus.busy <= 1'b0;
              state    <= DONE;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2 -- directed-sequence bench for maxpool_2x2 with randomized
// matrices checked against a plain-arithmetic pooling model.
module tb_maxpool_2x2;
  localparam int WIDTH = 16;
  localparam int SIZE  = 10;
  localparam int RW    = SIZE / 2;
  localparam int NWIN  = RW * RW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxpool_2x2_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();
  maxpool_2x2 #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;
  int mat  [SIZE][SIZE];
  int expm [RW][RW];
  int row0c [SIZE] = '{-188, 132, 2338, 5173, 7482, 7482, 5173, 2338, 132, -188};
  int row1c [SIZE] = '{-276, -55, 1941, 4101, 6811, 6811, 4101, 1941, -55, -276};
  int pool0c [RW]  = '{132, 5173, 7482, 5173, 132};
  int idle_v, idle_b, idle_d;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int nonzero_cnt();
    int n = 0;
    for (int i = 0; i < RW; i++)
      for (int j = 0; j < RW; j++)
        if (bus.out_matrix[i][j] !== '0) n++;
    return n;
  endfunction

  // Reference: max of four, or floor of the mean of four
  function automatic int ref_pool(input int a, input int b, input int c, input int d,
                                  input bit avg);
    int s, q;
    if (!avg) begin
      q = a;
      if (b > q) q = b;
      if (c > q) q = c;
      if (d > q) q = d;
      return q;
    end
    s = a + b + c + d;
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    return q;
  endfunction

  task automatic compute_expected(input bit avg);
    for (int i = 0; i < RW; i++)
      for (int j = 0; j < RW; j++)
        expm[i][j] = ref_pool(mat[2*i][2*j], mat[2*i][2*j+1],
                              mat[2*i+1][2*j], mat[2*i+1][2*j+1], avg);
  endtask

  task automatic gen_matrix(input bit directed);
    logic signed [WIDTH-1:0] t;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        t = WIDTH'($urandom);
        mat[i][j] = int'(t);
      end
    if (directed) begin
      for (int j = 0; j < SIZE; j++) begin
        mat[0][j] = row0c[j];
        mat[1][j] = row1c[j];
      end
      mat[4][6] = -5; mat[4][7] = -3; mat[5][6] = -8; mat[5][7] = -1;
    end
  endtask

  task automatic drive_matrix();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        bus.in_matrix[i][j] = WIDTH'(mat[i][j]);
  endtask

  // One complete run; optionally pulses start mid-run and in the done cycle.
  task automatic run(input bit avg, input bit extra, input string tag);
    int nv, nd, first_v, last_v, done_at, nbusy, bad;
    nv = 0; nd = 0; first_v = -1; last_v = -1; done_at = -1; nbusy = 0; bad = 0;
    compute_expected(avg);
    drive_matrix();
    @(negedge clk);
`ifdef MAXPOOL_AVG_EN
    bus.pool_mode = avg;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
`ifdef MAXPOOL_AVG_EN
    bus.pool_mode = ~avg;
`endif
    check({tag, "_busy_on"}, bus.busy, 1);
    if (bus.busy) nbusy++;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        bus.in_matrix[i][j] = WIDTH'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.start = extra && (cyc == 10 || cyc == NWIN + 1);
      if (bus.busy) nbusy++;
      if (bus.out_valid) begin
        if (nv < NWIN) begin
          check({tag, "_data"}, bus.out_data, expm[nv / RW][nv % RW]);
          check({tag, "_pos"}, int'(bus.out_row) * RW + int'(bus.out_col), nv);
        end
        if (first_v < 0) first_v = cyc;
        nv++;
        last_v = cyc;
      end
      if (bus.done) begin
        nd++;
        done_at = cyc;
      end
    end
    bus.start = 1'b0;
    check({tag, "_nvalid"}, nv, NWIN);
    check({tag, "_first_valid"}, first_v, 1);
    check({tag, "_last_valid"}, last_v, NWIN);
    check({tag, "_ndone"}, nd, 1);
    check({tag, "_done_at"}, done_at, NWIN + 1);
    check({tag, "_busy_cycles"}, nbusy, NWIN);
    check({tag, "_busy_off"}, bus.busy, 0);
    for (int i = 0; i < RW; i++)
      for (int j = 0; j < RW; j++)
        if (bus.out_matrix[i][j] !== WIDTH'(expm[i][j])) bad++;
    check({tag, "_matrix_bad"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
`ifdef MAXPOOL_AVG_EN
    bus.pool_mode = 1'b0;
`endif
    for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) mat[i][j] = 0;
    drive_matrix();
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_row", bus.out_row, 0);
    check("rst_col", bus.out_col, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_matrix_nz", nonzero_cnt(), 0);
    rst = 1'b0;

    idle_v = 0; idle_b = 0; idle_d = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) idle_v++;
      if (bus.busy !== 1'b0) idle_b++;
      if (bus.done !== 1'b0) idle_d++;
    end
    check("idle_valid", idle_v, 0);
    check("idle_busy", idle_b, 0);
    check("idle_done", idle_d, 0);
    check("idle_data", bus.out_data, 0);

    // Directed rows 0-1 and an all-negative window at block (2,3)
    gen_matrix(1'b1);
    run(1'b0, 1'b0, "dir");
    for (int k = 0; k < RW; k++)
      check("dir_row0_const", bus.out_matrix[0][k], pool0c[k]);
    check("dir_neg_window", bus.out_matrix[2][3], -1);

    // Extra starts mid-run and in the done cycle are ignored
    gen_matrix(1'b1);
    run(1'b0, 1'b1, "ignore_start");
    gen_matrix(1'b0);
    run(1'b0, 1'b0, "idle_start");

    // Asynchronous reset at window 12 aborts the run
    gen_matrix(1'b0);
    drive_matrix();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_running", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_row", bus.out_row, 0);
    check("mid_rst_matrix_nz", nonzero_cnt(), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_v = 0; idle_d = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) idle_v++;
      if (bus.done !== 1'b0) idle_d++;
    end
    check("abort_no_valid", idle_v, 0);
    check("abort_no_done", idle_d, 0);
    gen_matrix(1'b0);
    run(1'b0, 1'b0, "after_rst");

`ifdef MAXPOOL_AVG_EN
    gen_matrix(1'b1);
    run(1'b1, 1'b0, "avg");
    check("avg_win00", bus.out_matrix[0][0], -97);
    run(1'b0, 1'b0, "max_same");
    check("max_win00", bus.out_matrix[0][0], 132);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
